sr_flag_arbiter: RTL and testbench

SR_FLAG_ARBITER -- requirements
Module: sr_flag_arbiter

---
 rtl/sr_flag_arbiter.sv | 148 ++++++++++++++
 tb/tb_sr_flag_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that drives set/reset strobes into eight SR flag latches and keeps a shadow copy of them.
// Optional collision counter is enabled by defining SR_CONFLICT_CNT_EN.
module sr_flag_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [3:0]  op,
    input  logic [11:0] idx,
    output logic [3:0]  gnt,
    output logic [7:0]  s_out,
    output logic [7:0]  r_out,
    output logic [7:0]  q,
    output logic        busy,
    output logic [7:0]  conflict_cnt
);

    typedef enum logic [1:0] {IDLE, APPLY, RELEASE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  rr_q, rr_d;
    logic        op_q, op_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [7:0]  s_q, s_d, r_q, r_d, q_q, q_d;
    logic        busy_q, busy_d;

    logic [1:0]  win, cand;
    logic        win_vld;
    logic        win_op;
    logic [2:0]  win_idx;

    // First asserted request at or above rr_q, wrapping modulo 4.
    always_comb begin
        win     = rr_q;
        cand    = rr_q;
        win_vld = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            cand = rr_q + 2'(k);
            if (!win_vld && req[cand]) begin
                win     = cand;
                win_vld = 1'b1;
            end
        end
        win_op  = op[win];
        win_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (win == 2'(i)) win_idx = idx[3*i +: 3];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            op_q    <= 1'b0;
            idx_q   <= '0;
            gnt_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        op_d    = op_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = APPLY;
                    rr_d    = win + 2'd1;
                    op_d    = win_op;
                    idx_d   = win_idx;
                end
            end
            APPLY:   state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are computed one cycle ahead so they are flop outputs during APPLY.
    always_comb begin
        gnt_d  = '0;
        s_d    = '0;
        r_d    = '0;
        q_d    = q_q;
        busy_d = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d[win] = 1'b1;
                    if (win_op) s_d[win_idx] = 1'b1;
                    else        r_d[win_idx] = 1'b1;
                end
            end
            APPLY:   q_d[idx_q] = op_q;
            default: ;
        endcase
    end

    assign gnt   = gnt_q;
    assign s_out = s_q;
    assign r_out = r_q;
    assign q     = q_q;
    assign busy  = busy_q;

`ifdef SR_CONFLICT_CNT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       collide;

    always_comb begin
        collide = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            for (int unsigned j = i + 1; j < 4; j++) begin
                if (req[i] && req[j] && (idx[3*i +: 3] == idx[3*j +: 3]) && (op[i] != op[j]))
                    collide = 1'b1;
            end
        end
        cnt_d = cnt_q;
        if ((state_q == IDLE) && collide && (cnt_q != 8'hFF))
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign conflict_cnt = cnt_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: table of single operations plus round-robin, collision,
// reset-abort and counter-saturation sequences.
module tb_sr_flag_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  op;
    logic [11:0] idx;
    logic [3:0]  gnt;
    logic [7:0]  s_out, r_out, q;
    logic        busy;
    logic [7:0]  conflict_cnt;

    int errors = 0;
    int checks = 0;

    sr_flag_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .op           (op),
        .idx          (idx),
        .gnt          (gnt),
        .s_out        (s_out),
        .r_out        (r_out),
        .q            (q),
        .busy         (busy),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  op;
        logic [11:0] idx;
        logic [3:0]  gnt;
        logic [7:0]  s;
        logic [7:0]  r;
        logic [7:0]  q;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        op    = '0;
        idx   = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_gnt(output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (gnt != 4'd0) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // Strobe exclusivity on every flag, every cycle.
    always @(negedge clk) begin
        checks++;
        if ((s_out & r_out) != 8'd0) begin
            errors++;
            $display("FAIL sr_overlap: s_out=0x%0h r_out=0x%0h at %0t", s_out, r_out, $time);
        end
    end

    initial begin
        logic  ok;
        time   tprev;

        vt[0] = '{4'b0001, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd3}, 4'b0001, 8'h08, 8'h00, 8'h08};
        vt[1] = '{4'b0100, 4'b0100, {3'd0, 3'd6, 3'd0, 3'd0}, 4'b0100, 8'h40, 8'h00, 8'h48};
        vt[2] = '{4'b0011, 4'b0010, {3'd0, 3'd0, 3'd1, 3'd3}, 4'b0001, 8'h00, 8'h08, 8'h40};
        vt[3] = '{4'b1010, 4'b1000, {3'd0, 3'd0, 3'd6, 3'd0}, 4'b0010, 8'h00, 8'h40, 8'h00};
        vt[4] = '{4'b1010, 4'b1000, {3'd0, 3'd0, 3'd6, 3'd0}, 4'b1000, 8'h01, 8'h00, 8'h01};
        vt[5] = '{4'b1111, 4'b1111, {3'd2, 3'd4, 3'd5, 3'd7}, 4'b0001, 8'h80, 8'h00, 8'h81};
        vt[6] = '{4'b0010, 4'b0010, {3'd0, 3'd0, 3'd0, 3'd0}, 4'b0010, 8'h01, 8'h00, 8'h81};

        rst_n = 1'b0;
        req   = '0;
        op    = '0;
        idx   = '0;
        #12;
        chk("rst_gnt",  32'(gnt),   32'd0);
        chk("rst_s",    32'(s_out), 32'd0);
        chk("rst_r",    32'(r_out), 32'd0);
        chk("rst_q",    32'(q),     32'd0);
        chk("rst_busy", 32'(busy),  32'd0);
        chk("rst_cnt",  32'(conflict_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            req = vt[i].req;
            op  = vt[i].op;
            idx = vt[i].idx;
            tick();
            chk($sformatf("v%0d_gnt", i),  32'(gnt),   32'(vt[i].gnt));
            chk($sformatf("v%0d_s", i),    32'(s_out), 32'(vt[i].s));
            chk($sformatf("v%0d_r", i),    32'(r_out), 32'(vt[i].r));
            chk($sformatf("v%0d_busy1", i), 32'(busy), 32'd1);
            req = '0;
            tick();
            chk($sformatf("v%0d_rel_strb", i), 32'({gnt, s_out, r_out}), 32'd0);
            chk($sformatf("v%0d_q", i),     32'(q),    32'(vt[i].q));
            chk($sformatf("v%0d_busy2", i), 32'(busy), 32'd1);
            tick();
            chk($sformatf("v%0d_idle", i),  32'({busy, gnt, s_out, r_out}), 32'd0);
        end
        chk("tbl_cnt", 32'(conflict_cnt), 32'd0);

        // Round robin with all four requesters, each dropping after its grant.
        do_reset();
        req = 4'b1111;
        op  = 4'b1111;
        idx = {3'd4, 3'd3, 3'd2, 3'd1};
        tprev = 0;
        for (int n = 0; n < 4; n++) begin
            wait_gnt(ok);
            chk($sformatf("rr%0d_timeout", n), 32'(ok), 32'd1);
            chk($sformatf("rr%0d_gnt", n), 32'(gnt), 32'(4'b0001 << n));
            if (n > 0) chk($sformatf("rr%0d_spacing", n), 32'(($time - tprev) / 10), 32'd3);
            tprev = $time;
            req[n] = 1'b0;
            tick();
        end
        chk("rr_q", 32'(q), 32'h1E);
        tick();
        req = 4'b1111;
        tick();
        chk("rr_wrap", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        tick();

        // Collision on flag 5 with rr_ptr steered to 2.
        do_reset();
        req = 4'b0010;
        op  = 4'b0010;
        idx = '0;
        tick();
        req = '0;
        tick();
        tick();
        req = 4'b0110;
        op  = 4'b0010;
        idx = {3'd0, 3'd5, 3'd5, 3'd0};
        tick();
        chk("col_gnt_a", 32'(gnt),   32'b0100);
        chk("col_r_a",   32'(r_out), 32'h20);
        req[2] = 1'b0;
        tick();
        tick();
        tick();
        chk("col_gnt_b", 32'(gnt),   32'b0010);
        chk("col_s_b",   32'(s_out), 32'h20);
        req = '0;
        tick();
        chk("col_q", 32'(q), 32'h21);
`ifdef SR_CONFLICT_CNT_EN
        chk("col_cnt", 32'(conflict_cnt), 32'd1);
`else
        chk("col_cnt", 32'(conflict_cnt), 32'd0);
`endif
        tick();

        // Reset asserted while the set strobe is active.
        do_reset();
        req = 4'b0001;
        op  = 4'b0001;
        idx = '0;
        tick();
        chk("ra_s", 32'(s_out), 32'h01);
        rst_n = 1'b0;
        #1;
        chk("ra_clear", 32'({gnt, s_out, r_out, q, busy}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ra_q_after", 32'(q), 32'd0);
        tick();
        chk("ra_rearb", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        chk("ra_q_final", 32'(q), 32'h01);
        tick();

`ifdef SR_CONFLICT_CNT_EN
        // Hold an opposing pair so every IDLE cycle is a collision.
        do_reset();
        req = 4'b0011;
        op  = 4'b0001;
        idx = {3'd0, 3'd0, 3'd2, 3'd2};
        repeat (910) tick();
        chk("sat_cnt", 32'(conflict_cnt), 32'd255);
        req = '0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
